// File: rtl/tdes_sequencer.sv
// tdes_sequencer
//
// Runs one shared single-DES engine three times per block to build
// Triple-DES with EDE keying:
//   encrypt: E(K1), D(K2), E(K3)
//   decrypt: D(K3), E(K2), D(K1)
// If the engine never answers a pass, a watchdog aborts the block and
// returns it with out_err set and out_data cleared.
//
// Optional feature macro: TDES_SINGLE_PASS_EN
//   defined   - in_single = 1 at accept runs only pass 0 (K1, direction
//               taken from in_decrypt).
//   undefined - in_single is ignored; every block runs three passes.
//
// Parameters
//   TIMEOUT  cycles to wait for des_done per pass (2 .. 2**CNT_W-1)
//   CNT_W    watchdog counter width
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid / in_ready           input block handshake
//   in_data, in_key1..3           block and user keys K1..K3
//   in_decrypt, in_single         direction (1 = decrypt), single-pass request
//   des_start                     one-cycle start pulse to the engine
//   des_data, des_key             engine block and key (held START..WAIT)
//   des_encr_decr                 engine direction (0 = encrypt)
//   des_done, des_result          engine completion pulse and result
//   out_valid / out_ready         result handshake
//   out_data, out_err             result block, timeout-abort flag
module tdes_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key1,
  input  logic [63:0] in_key2,
  input  logic [63:0] in_key3,
  input  logic        in_decrypt,
  input  logic        in_single,
  output logic        des_start,
  output logic [63:0] des_data,
  output logic [63:0] des_key,
  output logic        des_encr_decr,
  input  logic        des_done,
  input  logic [63:0] des_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [63:0]      work_q;
  logic [63:0]      key1_q, key2_q, key3_q;
  logic             dec_q;
  logic             err_q;
  logic [1:0]       pass_q;
  logic [CNT_W-1:0] wdog_q;

  logic [63:0]      key_sel;
  logic             dir_sel;
  logic             last_pass;
  logic             accept;
  logic             done_ok;
  logic             timeout;

`ifdef TDES_SINGLE_PASS_EN
  logic single_q;
  assign last_pass = (pass_q == 2'd2) || single_q;
`else
  logic unused_single;
  assign unused_single = in_single;
  assign last_pass     = (pass_q == 2'd2);
`endif

  assign accept  = (state_q == IDLE) && in_valid;
  assign done_ok = (state_q == WAIT) && des_done;
  // des_done in the timeout cycle takes priority, so no error is raised.
  assign timeout = (state_q == WAIT) && !des_done && (wdog_q == WDOG_LAST);

  // Key/direction schedule. Pass 1 always uses K2 in the opposite
  // direction; the outer passes use K1 first when encrypting and K3
  // first when decrypting.
  always_comb begin
    key_sel = (pass_q == 2'd1) ? key2_q
            : (((pass_q == 2'd0) != dec_q) ? key1_q : key3_q);
    dir_sel = dec_q ^ (pass_q == 2'd1);
`ifdef TDES_SINGLE_PASS_EN
    if (single_q) begin
      key_sel = key1_q;
      dir_sel = dec_q;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      key1_q  <= '0;
      key2_q  <= '0;
      key3_q  <= '0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
      pass_q  <= 2'd0;
      wdog_q  <= '0;
`ifdef TDES_SINGLE_PASS_EN
      single_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;

      if (accept) begin
        work_q <= in_data;
        key1_q <= in_key1;
        key2_q <= in_key2;
        key3_q <= in_key3;
        dec_q  <= in_decrypt;
        pass_q <= 2'd0;
        err_q  <= 1'b0;
`ifdef TDES_SINGLE_PASS_EN
        single_q <= in_single;
`endif
      end

      if (state_q == START) begin
        wdog_q <= '0;
      end else if (state_q == WAIT) begin
        wdog_q <= wdog_q + 1'b1;
      end

      if (done_ok) begin
        work_q <= des_result;
        if (pass_q != 2'd2) begin
          pass_q <= pass_q + 2'd1;
        end
      end else if (timeout) begin
        work_q <= '0;
        err_q  <= 1'b1;
      end

      if ((state_q == OUT) && out_ready) begin
        err_q <= 1'b0;
      end
    end
  end

  // NOTE: every output and next-state value gets a default before the case
  // so no path through this block can infer a latch.
  always_comb begin
    state_d       = state_q;
    in_ready      = 1'b0;
    des_start     = 1'b0;
    des_data      = '0;
    des_key       = '0;
    des_encr_decr = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_err       = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = START;
      end
      START: begin
        des_start     = 1'b1;
        des_data      = work_q;
        des_key       = key_sel;
        des_encr_decr = dir_sel;
        state_d       = WAIT;
      end
      WAIT: begin
        des_data      = work_q;
        des_key       = key_sel;
        des_encr_decr = dir_sel;
        if (des_done) begin
          state_d = last_pass ? OUT : START;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = work_q;
        out_err   = err_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/tdes_sequencer.md
# tdes_sequencer

Controller that runs one shared single-DES engine three times per block to give Triple-DES (EDE keying). It accepts a 64-bit block and three 64-bit keys over a valid/ready handshake. It issues three start/done transactions to the DES engine, choosing key and direction for each pass, and returns the result over a valid/ready output handshake. A watchdog aborts a pass whose engine never answers.

## Interface
- TIMEOUT, 64: maximum cycles to wait for `des_done` per pass; legal range 2..2^CNT_W-1.
- CNT_W, 8: width of the watchdog counter.

- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request holds a valid block.
- in_ready  out  1  sequencer can accept a block.
- in_data  in  64  plaintext or ciphertext block.
- in_key1 / in_key2 / in_key3  in  64 each  user keys K1, K2, K3.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt.
- in_single  in  1  request a single-DES pass with K1 (see Configuration).
- des_start  out  1  one-cycle start pulse to the engine.
- des_data  out  64  engine input block.
- des_key  out  64  engine key.
- des_encr_decr  out  1  engine direction; 0 = encrypt.
- des_done  in  1  one-cycle pulse: engine result valid.
- des_result  in  64  engine output block.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  64  result block.
- out_err  out  1  result is a timeout abort; `out_data` is 0.

## Operation
- States: IDLE, START, WAIT, OUT.
- IDLE
  - `in_ready` = 1.
  - On `in_valid & in_ready`, register data, keys, mode and single. Set pass = 0. Go to START.
- START
  - Drive `des_start` = 1 for one cycle.
  - Drive `des_data` from the working register; it holds `in_data` on pass 0 and the previous `des_result` after that.
  - Drive `des_key` and `des_encr_decr` for the current pass. Clear the watchdog. Go to WAIT.
- Pass schedule
  - Encrypt: E(K1), D(K2), E(K3).
  - Decrypt: D(K3), E(K2), D(K1).
- WAIT: the watchdog increments each cycle.
  - On `des_done`, capture `des_result` into the working register. If pass < 2, increment pass and go to START. If pass = 2, go to OUT.
  - If the watchdog reaches TIMEOUT-1 without `des_done`, set the error flag, clear the working register and go to OUT.
  - `des_done` in the same cycle as a timeout: `des_done` wins and no error is raised.
- OUT
  - `out_valid` = 1; `out_data` = working register; `out_err` = error flag.
  - Hold until `out_ready`, then go to IDLE with the error flag cleared.
  - `in_ready` stays 0 in OUT; there is no bypass.
- `des_done` outside WAIT is ignored, including in the START cycle.
- `des_data`, `des_key` and `des_encr_decr` hold their values from START through WAIT.
- The pass counter saturates at 2; it never wraps.
- Reset mid-operation drops any in-flight block and returns to IDLE.

## Timing
- Reset values
  - `in_ready` = 1.
  - `des_start`, `des_encr_decr`, `out_valid` and `out_err` = 0.
  - `des_data`, `des_key` and `out_data` = 0.
- Let cycle 0 be the accept cycle and L the engine latency (`des_done` arrives L cycles after `des_start`, L ≥ 1).
  - Pass 0 starts at cycle 1.
  - Pass 1 starts at cycle 2+L.
  - Pass 2 starts at cycle 3+2L.
  - `out_valid` rises at cycle 4+3L.
- In single mode, `out_valid` rises at cycle 2+L.
- Throughput: one block per 5+3L cycles when `out_ready` is held high.
- A timeout on pass p raises `out_valid` TIMEOUT+1 cycles after that pass's START.

## Configuration
- Macro: TDES_SINGLE_PASS_EN.
- Defined: `in_single` = 1 at accept runs only pass 0, with K1 and the direction from `in_decrypt`, then goes to OUT.
- Undefined: `in_single` is ignored and every block runs three passes.

## Test plan
- Encrypt, engine model with L = 17, K1 = K2 = K3 = 0x133457799BBCDFF1, data 0x0123456789ABCDEF.
  - `out_valid` at cycle 55.
  - `out_data` = 0x85E813540F0AB405, which equals single-DES encryption.
  - `des_encr_decr` sequence is 0, 1, 0.
- Decrypt, same keys, data 0x85E813540F0AB405.
  - `out_data` = 0x0123456789ABCDEF.
  - `des_key` sequence is K3, K2, K1.
- Back-pressure: hold `out_ready` = 0 for 20 cycles after `out_valid`.
  - `out_valid` and `out_data` stay stable.
  - `in_ready` stays 0.
  - IDLE is entered on the cycle after `out_ready`.
- Timeout, TIMEOUT = 8: engine never answers pass 1.
  - `out_valid` = 1 and `out_err` = 1 nine cycles after the pass-1 start.
  - `out_data` = 0.
  - The next block completes normally.
- Reset: assert `rst` during pass 2 WAIT.
  - All outputs go to their reset values immediately.
  - A late `des_done` after reset release is ignored.
  - `in_ready` = 1.
- With TDES_SINGLE_PASS_EN and `in_single` = 1, L = 17.
  - Exactly one `des_start` pulse.
  - `out_valid` at cycle 19.
